// File: rtl/enemy_unit_gen2.sv
// One enemy slot on the lane battlefield: spawn timer, typed deploy, advance/attack, damage and death hold.
// All outputs are registered; reached_end is decoded from registered state only.
module enemy_unit_gen2 #(
   parameter int POS_W       = 9,
   parameter int HP_W        = 8,
   parameter int DMG_W       = 8,
   parameter int POS_MAX     = 319,
   parameter int SPAWN_DELAY = 4095,
   parameter int DEAD_HOLD   = 10,
   parameter int HP_T1       = 255,
   parameter int HP_T2       = 191,
   parameter int HP_T3       = 127,
   parameter int PWR_T1      = 32,
   parameter int PWR_T2      = 64,
   parameter int PWR_T3      = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spawn_req,
   input  logic [1:0]       spawn_type,
   input  logic             move_scen,
   input  logic             damage_scen,
   input  logic [DMG_W-1:0] damage_in,
   input  logic [POS_W-1:0] unit_front,
   output logic [POS_W-1:0] position,
   output logic [DMG_W-1:0] damage_out,
   output logic             attack_valid,
   output logic [1:0]       enemy_type,
   output logic             alive,
   output logic             dead_pulse,
   output logic             reached_end
);

   localparam int CNT_MAX = (SPAWN_DELAY > DEAD_HOLD) ? SPAWN_DELAY : DEAD_HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int CMP_W   = (HP_W > DMG_W) ? HP_W : DMG_W;

   localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_DELAY);
   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_HOLD - 1);
   localparam logic [POS_W-1:0] POS_END    = POS_W'(POS_MAX);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_DEPLOY = 4'b0010,
      ST_ALIVE  = 4'b0100,
      ST_DEAD   = 4'b1000
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         type_q;
   logic [HP_W-1:0]    health_q;
   logic [DMG_W-1:0]   power_q;
   logic               div_q;

   logic [CMP_W-1:0]   hp_ext, dmg_ext;
   logic               deploy_go, kill, dead_done, advance, step_ok;

   function automatic logic [HP_W-1:0] type_health(input logic [1:0] t);
      case (t)
         2'd2:    return HP_W'(HP_T2);
         2'd3:    return HP_W'(HP_T3);
         default: return HP_W'(HP_T1);
      endcase
   endfunction

   function automatic logic [DMG_W-1:0] type_power(input logic [1:0] t);
      case (t)
         2'd2:    return DMG_W'(PWR_T2);
         2'd3:    return DMG_W'(PWR_T3);
         default: return DMG_W'(PWR_T1);
      endcase
   endfunction

   assign hp_ext    = CMP_W'(health_q);
   assign dmg_ext   = CMP_W'(damage_in);
   assign deploy_go = (state_q == ST_IDLE) && (spawn_req || (cnt_q == SPAWN_LAST));
   assign kill      = (state_q == ST_ALIVE) && damage_scen && (hp_ext <= dmg_ext);
   assign dead_done = (cnt_q == DEAD_LAST);
   assign advance   = move_scen && (unit_front > position);
   // Type 2 moves at half speed: only every second advance tick produces a step.
   assign step_ok   = (position != POS_END) && ((type_q != 2'd2) || div_q);

   assign reached_end = alive && (position == POS_END);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assigned before the case so no path leaves state_d unassigned (no latch).
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:   state_d = deploy_go ? ST_DEPLOY : ST_IDLE;
         ST_DEPLOY: state_d = ST_ALIVE;
         ST_ALIVE:  state_d = kill ? ST_DEAD : ST_ALIVE;
         ST_DEAD:   state_d = dead_done ? ST_IDLE : ST_DEAD;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         type_q       <= '0;
         health_q     <= '0;
         power_q      <= '0;
         div_q        <= 1'b0;
         position     <= '0;
         damage_out   <= '0;
         attack_valid <= 1'b0;
         enemy_type   <= '0;
         alive        <= 1'b0;
         dead_pulse   <= 1'b0;
      end else begin
         attack_valid <= 1'b0;
         dead_pulse   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               position   <= '0;
               damage_out <= '0;
               enemy_type <= '0;
               alive      <= 1'b0;
               if (deploy_go) begin
                  cnt_q  <= '0;
                  type_q <= (spawn_type == 2'd0) ? 2'd1 : spawn_type;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DEPLOY: begin
               health_q   <= type_health(type_q);
               power_q    <= type_power(type_q);
               enemy_type <= type_q;
               div_q      <= 1'b0;
               alive      <= 1'b1;
            end
            ST_ALIVE: begin
               if (kill) begin
                  dead_pulse <= 1'b1;
                  enemy_type <= '0;
                  damage_out <= '0;
                  alive      <= 1'b0;
                  cnt_q      <= '0;
               end else begin
                  if (damage_scen) health_q <= HP_W'(hp_ext - dmg_ext);
                  if (advance) begin
                     div_q      <= ~div_q;
                     damage_out <= '0;
                     if (step_ok) position <= position + POS_W'(1);
                  end else if (move_scen) begin
                     damage_out   <= power_q;
                     attack_valid <= 1'b1;
                  end
               end
            end
            ST_DEAD: begin
               if (dead_done) begin
                  cnt_q    <= '0;
                  position <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q      <= '0;
               position   <= '0;
               damage_out <= '0;
               enemy_type <= '0;
               alive      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_unit_gen2.sv
// Self-checking bench for enemy_unit_gen2: directed vector table, hand sequences and
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_enemy_unit_gen2;

   logic       clk = 1'b0;
   logic       reset;
   logic       spawn_req;
   logic [1:0] spawn_type;
   logic       move_scen;
   logic       damage_scen;
   logic [7:0] damage_in;
   logic [8:0] unit_front;
   logic [8:0] position;
   logic [7:0] damage_out;
   logic       attack_valid;
   logic [1:0] enemy_type;
   logic       alive;
   logic       dead_pulse;
   logic       reached_end;

   enemy_unit_gen2 dut (
      .clk          (clk),
      .reset        (reset),
      .spawn_req    (spawn_req),
      .spawn_type   (spawn_type),
      .move_scen    (move_scen),
      .damage_scen  (damage_scen),
      .damage_in    (damage_in),
      .unit_front   (unit_front),
      .position     (position),
      .damage_out   (damage_out),
      .attack_valid (attack_valid),
      .enemy_type   (enemy_type),
      .alive        (alive),
      .dead_pulse   (dead_pulse),
      .reached_end  (reached_end)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   string phase = "init";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Behavioural model: a mode, a wait timer, and the unit's game attributes.
   localparam int M_IDLE = 0, M_DEPLOY = 1, M_ALIVE = 2, M_DEAD = 3;
   int hp_tab[4]  = '{0, 255, 191, 127};
   int pwr_tab[4] = '{0, 32, 64, 128};
   int m_mode, m_wait, m_pos, m_hp, m_pwr, m_type, m_pend, m_dmg, m_moves;
   bit m_atk, m_pulse;

   function automatic void model_reset();
      m_mode = M_IDLE; m_wait = 0; m_pos = 0; m_hp = 0; m_pwr = 0;
      m_type = 0; m_pend = 0; m_dmg = 0; m_moves = 0; m_atk = 0; m_pulse = 0;
   endfunction

   function automatic void model_step();
      m_atk = 0;
      m_pulse = 0;
      case (m_mode)
         M_IDLE: begin
            m_pos = 0;
            m_dmg = 0;
            if (spawn_req || m_wait == 4095) begin
               m_mode = M_DEPLOY;
               m_pend = (spawn_type == 2'd0) ? 1 : int'(spawn_type);
               m_wait = 0;
            end else m_wait++;
         end
         M_DEPLOY: begin
            m_mode = M_ALIVE; m_type = m_pend;
            m_hp = hp_tab[m_pend]; m_pwr = pwr_tab[m_pend];
            m_moves = 0; m_dmg = 0;
         end
         M_ALIVE: begin
            if (damage_scen && int'(damage_in) >= m_hp) begin
               m_mode = M_DEAD; m_pulse = 1; m_wait = 0; m_dmg = 0;
            end else begin
               if (damage_scen) m_hp -= int'(damage_in);
               if (move_scen) begin
                  if (int'(unit_front) > m_pos) begin
                     m_moves++;
                     if ((m_type != 2 || m_moves % 2 == 0) && m_pos < 319) m_pos++;
                     m_dmg = 0;
                  end else begin
                     m_dmg = m_pwr;
                     m_atk = 1;
                  end
               end
            end
         end
         default: begin
            m_wait++;
            if (m_wait == 10) begin
               m_mode = M_IDLE; m_wait = 0; m_pos = 0;
            end
         end
      endcase
   endfunction

   function automatic logic [22:0] pack_dut();
      return {position, damage_out, attack_valid, enemy_type, alive, dead_pulse, reached_end};
   endfunction

   function automatic logic [22:0] pack_model();
      bit a;
      a = (m_mode == M_ALIVE);
      return {9'(m_pos), a ? 8'(m_dmg) : 8'd0, m_atk, a ? 2'(m_type) : 2'd0,
              a, m_pulse, a && (m_pos == 319)};
   endfunction

   task automatic drive(input bit sr, input int st, input bit mv, input bit ds,
                        input int di, input int uf);
      spawn_req = sr; spawn_type = 2'(st); move_scen = mv;
      damage_scen = ds; damage_in = 8'(di); unit_front = 9'(uf);
      @(posedge clk);
      model_step();
      #1;
      check(phase, 32'(pack_dut()), 32'(pack_model()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset(input string name);
      #2 reset = 1'b1;
      #1 check(name, 32'(pack_dut()), 32'd0);
      #2 reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit sr; int st; bit mv; bit ds; int di; int uf;
      int e_pos; int e_dmg; bit e_atk; int e_type; bit e_alive; bit e_pulse;
   } vec_t;
   vec_t tbl[12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1, 2, 0, 0, 0,   0, 0,  0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0,   0, 0,  0, 0, 2, 1, 0};
      tbl[2]  = '{0, 0, 1, 0, 0, 100, 0,  0, 0, 2, 1, 0};
      tbl[3]  = '{0, 0, 1, 0, 0, 100, 1,  0, 0, 2, 1, 0};
      tbl[4]  = '{0, 0, 1, 0, 0, 100, 1,  0, 0, 2, 1, 0};
      tbl[5]  = '{0, 0, 1, 0, 0, 100, 2,  0, 0, 2, 1, 0};
      tbl[6]  = '{0, 0, 1, 0, 0,   2, 2, 64, 1, 2, 1, 0};
      tbl[7]  = '{0, 0, 0, 0, 0,   2, 2, 64, 0, 2, 1, 0};
      tbl[8]  = '{0, 0, 1, 0, 0,  50, 2,  0, 0, 2, 1, 0};
      tbl[9]  = '{0, 0, 0, 1, 190, 50, 2,  0, 0, 2, 1, 0};
      tbl[10] = '{0, 0, 1, 1, 1,  50, 2,  0, 0, 0, 0, 1};
      tbl[11] = '{1, 3, 0, 0, 0,  50, 2,  0, 0, 0, 0, 0};

      reset = 1'b1; spawn_req = 0; spawn_type = 0; move_scen = 0;
      damage_scen = 0; damage_in = 0; unit_front = 0;
      model_reset();
      #1 check("reset outputs", 32'(pack_dut()), 32'd0);
      #11 reset = 1'b0;

      // Auto-spawn after the full idle delay, default type 1, full health boundary.
      phase = "auto spawn";
      idle(4095);
      check("no deploy before delay", 32'(enemy_type), 32'd0);
      idle(1);
      check("deploy cycle alive low", 32'(alive), 32'd0);
      idle(1);
      check("auto type 1", 32'(enemy_type), 32'd1);
      check("auto alive", 32'(alive), 32'd1);
      check("auto pos/dmg", 32'({position, damage_out}), 32'd0);
      drive(0, 0, 0, 1, 254, 0);
      check("hp 255 survives 254", 32'(alive), 32'd1);
      drive(0, 0, 0, 1, 1, 0);
      check("hp 1 killed by 1", 32'(dead_pulse), 32'd1);
      idle(10);

      // Directed vector table: type 2 half speed, engage, damage and kill.
      do_reset("reset before table");
      phase = "table";
      idle(5);
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].sr, tbl[i].st, tbl[i].mv, tbl[i].ds, tbl[i].di, tbl[i].uf);
         check($sformatf("vec%0d", i),
               32'({position, damage_out, attack_valid, enemy_type, alive, dead_pulse}),
               32'({9'(tbl[i].e_pos), 8'(tbl[i].e_dmg), tbl[i].e_atk, 2'(tbl[i].e_type),
                    tbl[i].e_alive, tbl[i].e_pulse}));
      end
      idle(12);

      // Type 3 attack at equal position, then advance.
      do_reset("reset before type3");
      phase = "type3";
      drive(1, 3, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 0, 100);
      check("t3 pos 7", 32'(position), 32'd7);
      drive(0, 0, 1, 0, 0, 7);
      check("t3 attack dmg", 32'(damage_out), 32'd128);
      check("t3 attack valid", 32'(attack_valid), 32'd1);
      check("t3 attack holds pos", 32'(position), 32'd7);
      drive(0, 0, 0, 0, 0, 7);
      check("t3 attack pulse ends", 32'(attack_valid), 32'd0);
      drive(0, 0, 1, 0, 0, 20);
      check("t3 advance pos", 32'(position), 32'd8);
      check("t3 advance dmg", 32'(damage_out), 32'd0);

      // Type 1 damage then kill with simultaneous move; dead hold and spawn_req ignored.
      do_reset("reset before kill");
      phase = "kill";
      drive(1, 1, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 100);
      drive(0, 0, 0, 1, 100, 100);
      check("hp 155 alive", 32'(alive), 32'd1);
      drive(0, 0, 1, 1, 155, 100);
      check("kill pulse", 32'(dead_pulse), 32'd1);
      check("kill no move", 32'(position), 32'd3);
      check("kill type cleared", 32'(enemy_type), 32'd0);
      for (int i = 0; i < 9; i++) drive(1, 2, 0, 0, 0, 0);
      check("dead holds pos", 32'(position), 32'd3);
      check("dead ignores spawn", 32'(alive), 32'd0);
      idle(1);
      check("back to idle pos 0", 32'(position), 32'd0);
      idle(3);

      // Saturation at the far end of the lane.
      do_reset("reset before end");
      phase = "lane end";
      drive(1, 1, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 318; i++) drive(0, 0, 1, 0, 0, 511);
      check("pos 318", 32'({position, reached_end}), 32'({9'd318, 1'b0}));
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 511);
      check("pos saturates", 32'(position), 32'd319);
      check("reached_end", 32'(reached_end), 32'd1);

      // Async reset while alive at position 50, then full spawn delay again.
      do_reset("reset before mid-alive");
      phase = "mid reset";
      drive(1, 1, 0, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 50; i++) drive(0, 0, 1, 0, 0, 511);
      check("pos 50", 32'(position), 32'd50);
      do_reset("async reset while alive");
      idle(4096);
      check("no early respawn", 32'(alive), 32'd0);
      idle(1);
      check("respawn after delay", 32'(alive), 32'd1);

      // Randomized traffic against the model.
      phase = "random";
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 99) < 3, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
               $urandom_range(0, 4) == 0, $urandom_range(0, 60), $urandom_range(0, 60));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
